// File: rtl/alu_flag_unit_pkg.sv
// +------------------------------------------------------------------+
// | alu_flag_unit_pkg: shared flag-mode/state enums, flag bit indices |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package alu_flag_unit_pkg;

  typedef enum logic [1:0] {
    MODE_KEEP = 2'd0,
    MODE_CLR  = 2'd1,
    MODE_SET  = 2'd2,
    MODE_ALU  = 2'd3
  } flag_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LO = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

endpackage

`default_nettype wire

// File: rtl/alu_flag_unit_if.sv
// +------------------------------------------------------------------+
// | alu_flag_unit_if: control/pass/flag bus of the flag capture unit  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

interface alu_flag_unit_if;
  import alu_flag_unit_pkg::*;

  logic       start;
  logic       sub;
  flag_mode_e zmode;
  flag_mode_e nmode;
  flag_mode_e hmode;
  flag_mode_e cmode;
  logic       pass_lo;
  logic       pass_hi;
  logic [3:0] nib;
  logic       alu_carry;
  logic       f_we;
  logic [3:0] f_in;
  logic [7:0] result;
  logic       flag_z;
  logic       flag_n;
  logic       flag_h;
  logic       flag_c;
  logic       busy;
  logic       done;

  modport master (
    output start, sub, zmode, nmode, hmode, cmode,
    output pass_lo, pass_hi, nib, alu_carry, f_we, f_in,
    input  result, flag_z, flag_n, flag_h, flag_c, busy, done
  );

  modport slave (
    input  start, sub, zmode, nmode, hmode, cmode,
    input  pass_lo, pass_hi, nib, alu_carry, f_we, f_in,
    output result, flag_z, flag_n, flag_h, flag_c, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/alu_flag_sel.sv
// +------------------------------------------------------------------+
// | alu_flag_sel: picks one flag's next value from its update policy  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module alu_flag_sel
  import alu_flag_unit_pkg::*;
(
  input  flag_mode_e mode,
  input  logic       old_flag,
  input  logic       computed,
  output logic       new_flag
);

  always_comb begin
    new_flag = old_flag;
    case (mode)
      MODE_KEEP: new_flag = old_flag;
      MODE_CLR:  new_flag = 1'b0;
      MODE_SET:  new_flag = 1'b1;
      MODE_ALU:  new_flag = computed;
      default:   new_flag = old_flag;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_flag_unit.sv
// +------------------------------------------------------------------+
// | alu_flag_unit: two-pass nibble result assembly and flag commit    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module alu_flag_unit
  import alu_flag_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  alu_flag_unit_if.slave bus
);

  state_e     state_q, state_d;
  logic       sub_q, sub_d;
  flag_mode_e mode_q [4];
  flag_mode_e mode_d [4];
  logic [7:0] result_q, result_d;
  logic [3:0] flags_q, flags_d;
  logic       hc_q, hc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] result_new;
  logic [3:0] flag_alu;
  logic [3:0] flag_sel;

  // Z must see the full byte as it will be after this high pass
  assign result_new       = {bus.nib, result_q[3:0]};
  assign flag_alu[FLAG_Z] = (result_new == 8'h00);
  assign flag_alu[FLAG_N] = sub_q;
  assign flag_alu[FLAG_H] = hc_q ^ sub_q;
  assign flag_alu[FLAG_C] = bus.alu_carry ^ sub_q;

  for (genvar i = 0; i < 4; i++) begin : g_flag
    alu_flag_sel u_sel (
      .mode     (mode_q[i]),
      .old_flag (flags_q[i]),
      .computed (flag_alu[i]),
      .new_flag (flag_sel[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    mode_d   = mode_q;
    result_d = result_q;
    flags_d  = flags_q;
    hc_d     = hc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sub_d          = bus.sub;
          mode_d[FLAG_Z] = bus.zmode;
          mode_d[FLAG_N] = bus.nmode;
          mode_d[FLAG_H] = bus.hmode;
          mode_d[FLAG_C] = bus.cmode;
          state_d        = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (bus.pass_lo) begin
          result_d[3:0] = bus.nib;
          hc_d          = bus.alu_carry;
          state_d       = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (bus.pass_hi) begin
          result_d = result_new;
          flags_d  = flag_sel;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A direct load overrides whatever the commit would have written
    if (bus.f_we) begin
      flags_d = bus.f_in;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sub_q    <= 1'b0;
      for (int i = 0; i < 4; i++) mode_q[i] <= MODE_KEEP;
      result_q <= 8'h00;
      flags_q  <= 4'h0;
      hc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      hc_q     <= hc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.flag_z = flags_q[FLAG_Z];
  assign bus.flag_n = flags_q[FLAG_N];
  assign bus.flag_h = flags_q[FLAG_H];
  assign bus.flag_c = flags_q[FLAG_C];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_flag_unit.sv
// +------------------------------------------------------------------+
// | tb_alu_flag_unit: directed vectors for the flag capture unit      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_alu_flag_unit;
  import alu_flag_unit_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  alu_flag_unit_if bus ();

  alu_flag_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flags();
    return {4'h0, bus.flag_z, bus.flag_n, bus.flag_h, bus.flag_c};
  endfunction

  // start@t, pass_lo@t+1, pass_hi@t+2, done observed after t+2 edge
  task automatic run_seq(input string tag, input logic sub,
                         input flag_mode_e zm, input flag_mode_e nm,
                         input flag_mode_e hm, input flag_mode_e cm,
                         input logic [3:0] lo_nib, input logic lo_c,
                         input logic [3:0] hi_nib, input logic hi_c,
                         input logic glitch_hi, input logic fwe, input logic [3:0] fin,
                         input logic [7:0] exp_res, input logic [3:0] exp_flags);
    bus.start = 1'b1; bus.sub = sub;
    bus.zmode = zm; bus.nmode = nm; bus.hmode = hm; bus.cmode = cm;
    step();
    bus.start = 1'b0;
    check({tag, "_busy"}, {7'd0, bus.busy}, 8'd1);
    if (glitch_hi) begin
      bus.pass_hi = 1'b1; bus.nib = 4'hA; bus.alu_carry = 1'b1;
      step();
      bus.pass_hi = 1'b0;
    end
    bus.pass_lo = 1'b1; bus.nib = lo_nib; bus.alu_carry = lo_c;
    step();
    bus.pass_lo = 1'b0;
    check({tag, "_nodone_mid"}, {7'd0, bus.done}, 8'd0);
    bus.pass_hi = 1'b1; bus.nib = hi_nib; bus.alu_carry = hi_c;
    bus.f_we = fwe; bus.f_in = fin;
    step();
    bus.pass_hi = 1'b0; bus.f_we = 1'b0; bus.f_in = 4'h0;
    check({tag, "_done"}, {7'd0, bus.done}, 8'd1);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_flags"}, flags(), {4'h0, exp_flags});
    step();
    check({tag, "_done_drop"}, {7'd0, bus.done}, 8'd0);
    check({tag, "_idle"}, {7'd0, bus.busy}, 8'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0;
    bus.zmode = MODE_KEEP; bus.nmode = MODE_KEEP;
    bus.hmode = MODE_KEEP; bus.cmode = MODE_KEEP;
    bus.pass_lo = 1'b0; bus.pass_hi = 1'b0; bus.nib = 4'h0;
    bus.alu_carry = 1'b0; bus.f_we = 1'b0; bus.f_in = 4'h0;
    step();
    step();
    reset = 1'b0;
    check("rst_result", bus.result, 8'h00);
    check("rst_flags", flags(), 8'h00);
    check("rst_busy", {7'd0, bus.busy}, 8'd0);
    check("rst_done", {7'd0, bus.done}, 8'd0);

    // NEG 0x01
    run_seq("neg", 1'b1, MODE_ALU, MODE_ALU, MODE_ALU, MODE_ALU,
            4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 8'hFF, 4'b0111);
    // ADD 0x0F+0x01, with a stray pass_hi during WAIT_LO that must be ignored
    run_seq("add", 1'b0, MODE_ALU, MODE_ALU, MODE_ALU, MODE_ALU,
            4'h0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h10, 4'b0010);
    // zero result
    run_seq("zero", 1'b0, MODE_ALU, MODE_ALU, MODE_ALU, MODE_ALU,
            4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 4'b1011);
    // modes with prior flags 1011
    run_seq("mode1", 1'b1, MODE_KEEP, MODE_CLR, MODE_SET, MODE_KEEP,
            4'h5, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 4'h0, 8'h35, 4'b1011);

    // direct load while idle
    bus.f_we = 1'b1; bus.f_in = 4'b0100;
    step();
    bus.f_we = 1'b0; bus.f_in = 4'h0;
    check("fwe_idle", flags(), 8'h04);
    check("fwe_idle_res", bus.result, 8'h35);

    run_seq("mode2", 1'b0, MODE_SET, MODE_KEEP, MODE_CLR, MODE_ALU,
            4'h2, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h02, 4'b1101);
    // f_we at the commit edge wins over ALU values 1011
    run_seq("fwe_commit", 1'b0, MODE_ALU, MODE_ALU, MODE_ALU, MODE_ALU,
            4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 4'b0101, 8'h00, 4'b0101);

    // reset mid-sequence, colliding with f_we
    bus.start = 1'b1; bus.sub = 1'b0;
    bus.zmode = MODE_ALU; bus.nmode = MODE_ALU; bus.hmode = MODE_ALU; bus.cmode = MODE_ALU;
    step();
    bus.start = 1'b0;
    bus.pass_lo = 1'b1; bus.nib = 4'h9; bus.alu_carry = 1'b1;
    step();
    bus.pass_lo = 1'b0;
    reset = 1'b1; bus.f_we = 1'b1; bus.f_in = 4'hF;
    step();
    reset = 1'b0; bus.f_we = 1'b0; bus.f_in = 4'h0;
    check("mrst_busy", {7'd0, bus.busy}, 8'd0);
    check("mrst_flags", flags(), 8'h00);
    check("mrst_result", bus.result, 8'h00);
    bus.pass_hi = 1'b1; bus.nib = 4'h7; bus.alu_carry = 1'b1;
    step();
    bus.pass_hi = 1'b0;
    check("mrst_hi_done", {7'd0, bus.done}, 8'd0);
    check("mrst_hi_busy", {7'd0, bus.busy}, 8'd0);
    check("mrst_hi_result", bus.result, 8'h00);
    check("mrst_hi_flags", flags(), 8'h00);
    step();
    check("mrst_late_done", {7'd0, bus.done}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_flag_unit.md
ALU_FLAG_UNIT -- requirements
Module: alu_flag_unit

Interface
REQ-001 SHALL have parameter: none; all widths are fixed.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begins one 8-bit flag capture sequence; honoured only in IDLE.
REQ-005 SHALL have port sub  input  1  operation is subtract-type; sampled with an accepted start.
REQ-006 SHALL have ports zmode/nmode/hmode/cmode  input  2 each  per-flag update policy; sampled with an accepted start.
REQ-007 SHALL have port pass_lo  input  1  low-nibble ALU pass is valid this cycle.
REQ-008 SHALL have port pass_hi  input  1  high-nibble ALU pass is valid this cycle.
REQ-009 SHALL have port nib  input  4  ALU nibble result of the current pass.
REQ-010 SHALL have port alu_carry  input  1  raw carry out of the current nibble pass.
REQ-011 SHALL have port f_we  input  1  direct flag load enable.
REQ-012 SHALL have port f_in  input  4  direct flag value {Z,N,H,C}.
REQ-013 SHALL have port result  output  8  assembled 8-bit result.
REQ-014 SHALL have ports flag_z, flag_n, flag_h, flag_c  output  1 each  architectural flags.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse; committed flags and result are valid.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT_LO -> WAIT_HI -> DONE -> IDLE.
REQ-018 SHALL, on start in IDLE, latch sub and the four modes, then enter WAIT_LO.
REQ-019 SHALL, on pass_lo in WAIT_LO, store nib into result[3:0] and alu_carry into the half-carry latch, then enter WAIT_HI.
REQ-020 SHALL, on pass_hi in WAIT_HI, store nib into result[7:4], commit the flags at that same edge, then enter DONE.
REQ-021 SHALL assert done only in DONE, for exactly one cycle; the earliest sequence is start@t, pass_lo@t+1, pass_hi@t+2, done@t+3.
REQ-022 SHALL ignore start in non-IDLE states, pass_lo outside WAIT_LO, pass_hi outside WAIT_HI, and pass_lo and pass_hi while start is being accepted.
REQ-023 SHALL, per flag at commit, apply the latched mode: KEEP holds the old value, CLR writes 0, SET writes 1, ALU writes the computed value.
REQ-024 SHALL compute the ALU values as Z = (result == 0), using the full new 8-bit value; N = sub; H = half-carry latch XOR sub; C = high-pass alu_carry XOR sub, so borrow is inverted carry.
REQ-025 SHALL, on f_we in any state, load {Z,N,H,C} from f_in; when f_we coincides with a commit, f_in wins for all four flags.
REQ-026 SHALL hold result and the flags stable at all times except at the commit edge, the f_we edge and the reset edge.
REQ-027 SHALL allow a new start in the cycle after DONE, with no idle bubble required.

Reset
REQ-028 SHALL, when reset is high at an edge, force IDLE, clear result to 0x00, clear all flags to 0, clear the half-carry latch, and deassert busy and done.
REQ-029 SHALL, on reset mid-sequence, abandon the sequence without committing flags; reset has priority over f_we and over both passes.

Structure
REQ-030 SHALL take the flag-mode enum (KEEP=0, CLR=1, SET=2, ALU=3), the FSM state enum and the f_in bit positions (Z=3, N=2, H=1, C=0) from the shared ALU package.
REQ-031 SHALL instantiate one sub-module alu_flag_sel per flag (inputs: mode, old, computed; output: new) and four instances in total.

Verification
REQ-032 SHALL check NEG 0x01 (sub=1, all modes ALU): lo nib=F with carry 0, hi nib=F with carry 0 -> result FF, Z0 N1 H1 C1, done@t+3.
REQ-033 SHALL check ADD 0x0F+0x01 (sub=0, all modes ALU): lo nib=0 with carry 1, hi nib=1 with carry 0 -> result 10, Z0 N0 H1 C0.
REQ-034 SHALL check a zero result (sub=0, all modes ALU): lo nib=0 with carry 1, hi nib=0 with carry 1 -> result 00, Z1 N0 H1 C1.
REQ-035 SHALL check mode handling: prior flags 1011, modes Z=KEEP N=CLR H=SET C=KEEP, any passes -> flags 1011 (Z1 N0 H1 C1).
REQ-036 SHALL check reset mid-operation: start, pass_lo, reset, then pass_hi -> busy 0, no done pulse, flags 0000, result 00.
REQ-037 SHALL check f_we at the commit edge with f_in=0101 -> flags 0101 regardless of the ALU values, and done still pulses.
